// File: rtl/mem_arbiter_if.sv
// Signal bundle for mem_arbiter: fetch and load/store request ports, shared response, memory port.
// master is the arbiter's view; slave is the surrounding system's view.
interface mem_arbiter_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;

  logic        ls_req_valid;
  logic        ls_req_ready;
  logic [31:0] ls_req_addr;
  logic        ls_req_wen;
  logic [31:0] ls_req_wdata;
  logic [3:0]  ls_req_wmask;
  logic        ls_rsp_valid;

  logic [31:0] rsp_data;
  logic        rsp_err;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  modport master (
    input  if_req_valid, if_req_addr,
    input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output if_req_ready, if_rsp_valid, ls_req_ready, ls_rsp_valid,
    output rsp_data, rsp_err,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask
  );

  modport slave (
    output if_req_valid, if_req_addr,
    output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  if_req_ready, if_rsp_valid, ls_req_ready, ls_rsp_valid,
    input  rsp_data, rsp_err,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store units,
// one transaction in flight, with a WAIT-state timeout that returns an error response.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic        owner_ls;
  logic        last_ls;
  logic [7:0]  count;
  logic        grant_if;
  logic        grant_ls;
  logic        capture_rsp;
  logic        timeout_hit;

  logic [31:0] req_addr;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic [31:0] rsp_data;
  logic        rsp_err;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state == IDLE) begin
      if (bus.if_req_valid && bus.ls_req_valid) begin
        grant_if = last_ls;
        grant_ls = !last_ls;
      end else begin
        grant_if = bus.if_req_valid;
        grant_ls = bus.ls_req_valid;
      end
    end
  end

  always_comb begin
    state_next  = state;
    capture_rsp = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: if (grant_if || grant_ls) state_next = REQ;
      REQ: begin
        if (bus.mem_req_ready) begin
          if (bus.mem_rsp_valid) begin
            capture_rsp = 1'b1;
            state_next  = RESP;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_rsp_valid) begin
          capture_rsp = 1'b1;
          state_next  = RESP;
        end else if (count == LAST_COUNT) begin
          timeout_hit = 1'b1;
          state_next  = RESP;
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 8'd0;
      last_ls   <= 1'b1;
      owner_ls  <= 1'b0;
      req_addr  <= 32'd0;
      req_wen   <= 1'b0;
      req_wdata <= 32'd0;
      req_wmask <= 4'd0;
      rsp_data  <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      count <= (state == WAIT) ? count + 8'd1 : 8'd0;

      // Fetches are always reads, so the write fields are forced to zero.
      if (grant_if) begin
        req_addr  <= bus.if_req_addr;
        req_wen   <= 1'b0;
        req_wdata <= 32'd0;
        req_wmask <= 4'd0;
        owner_ls  <= 1'b0;
        last_ls   <= 1'b0;
      end else if (grant_ls) begin
        req_addr  <= bus.ls_req_addr;
        req_wen   <= bus.ls_req_wen;
        req_wdata <= bus.ls_req_wdata;
        req_wmask <= bus.ls_req_wmask;
        owner_ls  <= 1'b1;
        last_ls   <= 1'b1;
      end

      if (capture_rsp) begin
        rsp_data <= bus.mem_rsp_data;
        rsp_err  <= 1'b0;
      end else if (timeout_hit) begin
        rsp_data <= 32'd0;
        rsp_err  <= 1'b1;
      end
    end
  end

  assign bus.if_req_ready  = grant_if;
  assign bus.ls_req_ready  = grant_ls;
  assign bus.mem_req_valid = (state == REQ);
  assign bus.mem_req_addr  = req_addr;
  assign bus.mem_req_wen   = req_wen;
  assign bus.mem_req_wdata = req_wdata;
  assign bus.mem_req_wmask = req_wmask;
  assign bus.if_rsp_valid  = (state == RESP) && !owner_ls;
  assign bus.ls_rsp_valid  = (state == RESP) && owner_ls;
  assign bus.rsp_data      = rsp_data;
  assign bus.rsp_err       = rsp_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (TIMEOUT=4): a behavioural memory answers requests,
// expected requests/responses are queued when stimulus is driven and popped as the DUT produces them.
module tb_mem_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          len;
  } req_t;

  typedef struct {
    logic        is_ls;
    logic [31:0] data;
    logic        err;
    int          lat;
  } rsp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   mem_stall;
  int   rsp_lat;
  req_t req_q[$];
  rsp_t rsp_q[$];

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'h8000_0413;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: inputs change on the falling edge; ready after mem_stall REQ cycles,
  // response rsp_lat cycles after the handshake (0 = same cycle).
  initial begin : memModel
    int          stall;
    int          wait_cnt;
    bit          pending;
    logic [31:0] pend_data;
    stall = 0;
    wait_cnt = 0;
    pending = 0;
    pend_data = 32'd0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'd0;
    forever begin
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = 32'd0;
      if (rst) begin
        pending = 0;
        stall = 0;
        continue;
      end
      if (pending) begin
        if (wait_cnt == 0) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = pend_data;
          pending = 0;
        end else begin
          wait_cnt--;
        end
      end else if (bus.mem_req_valid) begin
        if (stall < mem_stall) begin
          stall++;
        end else begin
          stall = 0;
          bus.mem_req_ready = 1'b1;
          if (rsp_lat == 0) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = memData(bus.mem_req_addr);
          end else begin
            pending   = 1;
            wait_cnt  = rsp_lat - 1;
            pend_data = memData(bus.mem_req_addr);
          end
        end
      end
    end
  end

  initial begin : monitor
    req_t q;
    rsp_t r;
    int   req_len;
    bit   busy;
    int   grant_cyc;
    req_len = 0;
    busy = 0;
    grant_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0;
        req_len = 0;
        continue;
      end
      if (busy) checkOutput("ready_busy", 64'({bus.if_req_ready, bus.ls_req_ready}), 64'd0);
      if (bus.mem_req_valid) begin
        if (req_q.size() == 0) begin
          checkOutput("req_unexpected", 64'd1, 64'd0);
        end else begin
          q = req_q[0];
          req_len++;
          checkOutput("req_addr_wdata", {bus.mem_req_addr, bus.mem_req_wdata}, {q.addr, q.wdata});
          checkOutput("req_wen_wmask", 64'({bus.mem_req_wen, bus.mem_req_wmask}), 64'({q.wen, q.wmask}));
          if (bus.mem_req_ready) begin
            checkOutput("req_len", 64'(req_len), 64'(q.len));
            void'(req_q.pop_front());
            req_len = 0;
          end
        end
      end
      if (bus.if_rsp_valid || bus.ls_rsp_valid) begin
        if (rsp_q.size() == 0) begin
          checkOutput("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          r = rsp_q.pop_front();
          checkOutput("rsp_owner", 64'({bus.if_rsp_valid, bus.ls_rsp_valid}),
                      r.is_ls ? 64'd1 : 64'd2);
          checkOutput("rsp_data", 64'(bus.rsp_data), 64'(r.data));
          checkOutput("rsp_err", 64'(bus.rsp_err), 64'(r.err));
          checkOutput("rsp_latency", 64'(cyc - grant_cyc), 64'(r.lat));
        end
        busy = 0;
      end
      if (bus.if_req_ready || bus.ls_req_ready) begin
        checkOutput("one_ready", 64'(bus.if_req_ready && bus.ls_req_ready), 64'd0);
        grant_cyc = cyc;
        busy = 1;
      end
    end
  end

  task automatic waitDrain();
    for (int c = 0; c < 100 && rsp_q.size() != 0; c++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("drain", 64'(rsp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic is_ls, input logic [31:0] addr, input logic wen,
                               input logic [31:0] wdata, input logic [3:0] wmask,
                               input logic err, input int lat, input int len);
    bit got;
    req_t q;
    rsp_t r;
    q.addr  = addr;
    q.wen   = is_ls ? wen : 1'b0;
    q.wdata = is_ls ? wdata : 32'd0;
    q.wmask = is_ls ? wmask : 4'd0;
    q.len   = len;
    r.is_ls = is_ls;
    r.data  = err ? 32'd0 : memData(addr);
    r.err   = err;
    r.lat   = lat;
    req_q.push_back(q);
    rsp_q.push_back(r);
    @(posedge clk);
    #1;
    if (is_ls) begin
      bus.ls_req_valid = 1'b1;
      bus.ls_req_addr  = addr;
      bus.ls_req_wen   = wen;
      bus.ls_req_wdata = wdata;
      bus.ls_req_wmask = wmask;
    end else begin
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = addr;
    end
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = is_ls ? bus.ls_req_ready : bus.if_req_ready;
    end
    checkOutput("grant", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;
    waitDrain();
  endtask

  // Both units request continuously; n grants expected, alternating from fetch.
  task automatic applyBoth(input int n);
    int   got;
    req_t q;
    rsp_t r;
    for (int i = 0; i < n; i++) begin
      q.addr  = (i % 2) ? 32'h1000_0000 : 32'h0000_1000;
      q.wen   = (i % 2) ? 1'b1 : 1'b0;
      q.wdata = (i % 2) ? 32'hDEAD_BEEF : 32'd0;
      q.wmask = (i % 2) ? 4'hF : 4'h0;
      q.len   = 1;
      r.is_ls = (i % 2) ? 1'b1 : 1'b0;
      r.data  = memData(q.addr);
      r.err   = 1'b0;
      r.lat   = 3;
      req_q.push_back(q);
      rsp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h0000_1000;
    bus.ls_req_valid = 1'b1;
    bus.ls_req_addr  = 32'h1000_0000;
    bus.ls_req_wen   = 1'b1;
    bus.ls_req_wdata = 32'hDEAD_BEEF;
    bus.ls_req_wmask = 4'hF;
    got = 0;
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge clk);
      if (bus.if_req_ready || bus.ls_req_ready) got++;
    end
    checkOutput("both_grants", 64'(got), 64'(n));
    @(posedge clk);
    #1;
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;
    waitDrain();
  endtask

  initial begin : main
    checks = 0;
    errors = 0;
    mem_stall = 0;
    rsp_lat = 1;
    rst = 1'b0;
    bus.if_req_valid = 1'b0;
    bus.if_req_addr  = 32'd0;
    bus.ls_req_valid = 1'b0;
    bus.ls_req_addr  = 32'd0;
    bus.ls_req_wen   = 1'b0;
    bus.ls_req_wdata = 32'd0;
    bus.ls_req_wmask = 4'd0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 64'({bus.if_req_ready, bus.ls_req_ready}), 64'd0);
    checkOutput("reset_mem_valid", 64'(bus.mem_req_valid), 64'd0);
    checkOutput("reset_mem_fields", {bus.mem_req_addr, bus.mem_req_wdata}, 64'd0);
    checkOutput("reset_mem_wen_wmask", 64'({bus.mem_req_wen, bus.mem_req_wmask}), 64'd0);
    checkOutput("reset_rsp_valid", 64'({bus.if_rsp_valid, bus.ls_rsp_valid}), 64'd0);
    checkOutput("reset_rsp", 64'({bus.rsp_err, bus.rsp_data}), 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;

    // Simultaneous requests after reset alternate fetch, store, fetch, store.
    applyBoth(4);

    // Lone fetch, immediate accept, data one cycle later; response data then holds.
    applyStimulus(1'b0, 32'h8000_0000, 1'b0, 32'd0, 4'd0, 1'b0, 3, 1);
    checkOutput("hold_data", 64'(bus.rsp_data), 64'h0000_0413);

    // Response in the same cycle as the handshake.
    rsp_lat = 0;
    applyStimulus(1'b1, 32'h1000_0010, 1'b0, 32'd0, 4'd0, 1'b0, 2, 1);

    // Memory stalls five cycles; request fields must stay put.
    mem_stall = 5;
    rsp_lat = 1;
    applyStimulus(1'b1, 32'h2000_0004, 1'b1, 32'hCAFE_F00D, 4'h3, 1'b0, 8, 6);
    mem_stall = 0;

    // Response on the last WAIT cycle beats the timeout.
    rsp_lat = 4;
    applyStimulus(1'b0, 32'h0000_0100, 1'b0, 32'd0, 4'd0, 1'b0, 6, 1);

    // Response arrives one cycle too late: error response, late strobe ignored.
    rsp_lat = 5;
    applyStimulus(1'b1, 32'h3000_0000, 1'b0, 32'd0, 4'd0, 1'b1, 6, 1);
    repeat (3) @(negedge clk);
    checkOutput("hold_err", 64'({bus.rsp_err, bus.rsp_data}), {31'd0, 1'b1, 32'd0});

    // Reset in the middle of WAIT drops the fetch without a response.
    rsp_lat = 20;
    begin
      req_t q;
      q.addr = 32'h0000_2000;
      q.wen = 1'b0;
      q.wdata = 32'd0;
      q.wmask = 4'd0;
      q.len = 1;
      req_q.push_back(q);
    end
    @(posedge clk);
    #1;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h0000_2000;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.if_req_ready) break;
    end
    @(posedge clk);
    #1;
    bus.if_req_valid = 1'b0;
    for (int c = 0; c < 50 && req_q.size() != 0; c++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("wait_handshake", 64'(req_q.size()), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("midreset_mem_valid", 64'(bus.mem_req_valid), 64'd0);
    checkOutput("midreset_mem_addr", 64'(bus.mem_req_addr), 64'd0);
    checkOutput("midreset_rsp", 64'({bus.if_rsp_valid, bus.ls_rsp_valid, bus.rsp_err}), 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    rsp_lat = 1;
    repeat (3) @(negedge clk);

    // Fetch won last before reset, yet must win again afterwards.
    applyBoth(2);

    repeat (5) @(negedge clk);
    checkOutput("final_req_q", 64'(req_q.size()), 64'd0);
    checkOutput("final_rsp_q", 64'(rsp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
